// File: rtl/score_sign_ctrl.sv
// Signed score keeper with a saturating update path, a sequential
// binary-to-BCD converter kicked off once per video frame, and a blink
// gate that flashes the sign/digit bitmaps while the score sits at its limit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for startOfFrame; display registers hold last result
// CONVERT | repeated subtract-10 of the snapshot magnitude, counting tens
// DONE    | latch sign/tens/ones into the display, pulse update_done
module score_sign_ctrl #(
   parameter int MAX_ABS      = 99,
   parameter int BLINK_FRAMES = 16
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       add_pulse,
   input  logic       sub_pulse,
   input  logic [3:0] amount,
   input  logic       clear,
   output logic       minus_on,
   output logic [3:0] tens_digit,
   output logic [3:0] ones_digit,
   output logic       digits_visible,
   output logic       busy,
   output logic       update_done
);

   localparam logic signed [8:0] LIM_POS    = 9'(MAX_ABS);
   localparam logic signed [8:0] LIM_NEG    = -LIM_POS;
   localparam logic        [7:0] LIM_MAG    = 8'(MAX_ABS);
   localparam logic        [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [7:0] score_q, score_d;
   logic signed [8:0] score_ext, step_ext, sum_ext;
   logic        [7:0] mag_d, mag_q;
   logic              at_limit;

   logic [6:0] rem_q, rem_d;
   logic [3:0] tens_q, tens_d;
   logic       neg_q, neg_d;
   logic       busy_d, done_d, minus_d;
   logic [3:0] tens_out_d, ones_out_d;
   logic [7:0] frame_cnt;

   // Next score: 9-bit signed sum so the +/-15 step cannot wrap before clamping.
   always_comb begin
      score_ext = {score_q[7], score_q};
      step_ext  = {5'b0_0000, amount};
      sum_ext   = score_ext;
      if (add_pulse && !sub_pulse) begin
         sum_ext = score_ext + step_ext;
      end else if (sub_pulse && !add_pulse) begin
         sum_ext = score_ext - step_ext;
      end
      if (clear) begin
         score_d = '0;
      end else if (sum_ext > LIM_POS) begin
         score_d = LIM_POS[7:0];
      end else if (sum_ext < LIM_NEG) begin
         score_d = LIM_NEG[7:0];
      end else begin
         score_d = sum_ext[7:0];
      end
   end

   // Magnitudes of the incoming score (for the snapshot) and of the held score (for the limit test).
   always_comb begin
      mag_d    = score_d[7] ? -score_d : score_d;
      mag_q    = score_q[7] ? -score_q : score_q;
      at_limit = (mag_q == LIM_MAG);
   end

   // Score register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   // Converter next-state and display next-values; a zero snapshot never has its sign bit set.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      tens_d     = tens_q;
      neg_d      = neg_q;
      busy_d     = busy;
      done_d     = 1'b0;
      minus_d    = minus_on;
      tens_out_d = tens_digit;
      ones_out_d = ones_digit;
      case (state_q)
         IDLE: begin
            if (startOfFrame) begin
               neg_d   = score_d[7];
               rem_d   = mag_d[6:0];
               tens_d  = '0;
               busy_d  = 1'b1;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            if (rem_q >= 7'd10) begin
               rem_d  = rem_q - 7'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            minus_d    = neg_q;
            tens_out_d = tens_q;
            ones_out_d = rem_q[3:0];
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter and display registers.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         tens_q      <= '0;
         neg_q       <= 1'b0;
         busy        <= 1'b0;
         update_done <= 1'b0;
         minus_on    <= 1'b0;
         tens_digit  <= '0;
         ones_digit  <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         tens_q      <= tens_d;
         neg_q       <= neg_d;
         busy        <= busy_d;
         update_done <= done_d;
         minus_on    <= minus_d;
         tens_digit  <= tens_out_d;
         ones_digit  <= ones_out_d;
      end
   end

   // Blink gate: runs on every frame regardless of converter state.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         frame_cnt      <= '0;
         digits_visible <= 1'b1;
      end else if (startOfFrame) begin
         if (at_limit) begin
            if (frame_cnt == BLINK_LAST) begin
               frame_cnt      <= '0;
               digits_visible <= ~digits_visible;
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end else begin
            frame_cnt      <= '0;
            digits_visible <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_score_sign_ctrl.sv
// Bench for score_sign_ctrl: directed scenarios plus a randomized run
// against a frame-level model (integer score, div/mod digits, frame counts).
module tb_score_sign_ctrl;

   localparam int MAX_ABS      = 99;
   localparam int BLINK_FRAMES = 16;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       add_pulse;
   logic       sub_pulse;
   logic [3:0] amount;
   logic       clear;
   logic       minus_on;
   logic [3:0] tens_digit;
   logic [3:0] ones_digit;
   logic       digits_visible;
   logic       busy;
   logic       update_done;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_score, m_cnt, edge_n, due;
   int m_tens, m_ones, p_tens, p_ones;
   bit m_vis, m_minus, m_done, m_busy, pend, p_minus;

   always #5 clk = ~clk;

   score_sign_ctrl #(.MAX_ABS(MAX_ABS), .BLINK_FRAMES(BLINK_FRAMES)) dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .add_pulse      (add_pulse),
      .sub_pulse      (sub_pulse),
      .amount         (amount),
      .clear          (clear),
      .minus_on       (minus_on),
      .tens_digit     (tens_digit),
      .ones_digit     (ones_digit),
      .digits_visible (digits_visible),
      .busy           (busy),
      .update_done    (update_done)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clamp(input int v);
      if (v > MAX_ABS) return MAX_ABS;
      if (v < -MAX_ABS) return -MAX_ABS;
      return v;
   endfunction

   // One clock: drive inputs, advance the model by the same edge, sample 1ns later.
   task automatic tick(input bit sof, input bit add, input bit sub, input logic [3:0] amt, input bit clr);
      int nxt, mag;
      startOfFrame = sof; add_pulse = add; sub_pulse = sub; amount = amt; clear = clr;
      @(posedge clk);
      edge_n++;
      if (sof) begin
         if (iabs(m_score) == MAX_ABS) begin
            m_cnt++;
            if (m_cnt == BLINK_FRAMES) begin m_cnt = 0; m_vis = !m_vis; end
         end else begin
            m_cnt = 0; m_vis = 1'b1;
         end
      end
      if (clr)             nxt = 0;
      else if (add && sub) nxt = m_score;
      else if (add)        nxt = clamp(m_score + int'(amt));
      else if (sub)        nxt = clamp(m_score - int'(amt));
      else                 nxt = m_score;
      m_done = 1'b0;
      if (pend && edge_n == due) begin
         m_minus = p_minus; m_tens = p_tens; m_ones = p_ones; m_done = 1'b1; pend = 1'b0;
      end else if (!pend && sof) begin
         mag = iabs(nxt);
         p_minus = (nxt < 0); p_tens = mag / 10; p_ones = mag % 10;
         due = edge_n + p_tens + 2; pend = 1'b1;
      end
      m_busy  = pend;
      m_score = nxt;
      #1;
      startOfFrame = 1'b0; add_pulse = 1'b0; sub_pulse = 1'b0; amount = 4'd0; clear = 1'b0;
   endtask

   task automatic do_reset(input bit noisy);
      resetN = 1'b0;
      startOfFrame = noisy; add_pulse = noisy; sub_pulse = 1'b0; amount = noisy ? 4'd15 : 4'd0; clear = 1'b0;
      @(posedge clk);
      edge_n++;
      m_score = 0; m_cnt = 0; m_vis = 1'b1; m_minus = 1'b0; m_tens = 0; m_ones = 0;
      m_done = 1'b0; m_busy = 1'b0; pend = 1'b0;
      #1;
      resetN = 1'b1; startOfFrame = 1'b0; add_pulse = 1'b0; amount = 4'd0;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      total++; if (minus_on !== 1'b0)       begin bad++; $display("FAIL rst_minus: got %0d want 0", minus_on); end
      total++; if (tens_digit !== 4'd0)     begin bad++; $display("FAIL rst_tens: got %0d want 0", tens_digit); end
      total++; if (ones_digit !== 4'd0)     begin bad++; $display("FAIL rst_ones: got %0d want 0", ones_digit); end
      total++; if (digits_visible !== 1'b1) begin bad++; $display("FAIL rst_vis: got %0d want 1", digits_visible); end
      total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
      total++; if (update_done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %0d want 0", update_done); end
   endtask

   task automatic test_positive();
      int pulses = 0;
      do_reset(1'b0);
      repeat (3) tick(1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         if (update_done === 1'b1) pulses++;
         if (i < 3) begin
            total++; if (busy !== 1'b1 || tens_digit !== 4'd0) begin bad++; $display("FAIL pos_busy edge %0d: got busy=%0d tens=%0d want 1 0", i, busy, tens_digit); end
         end
         if (i == 3) begin
            total++; if (update_done !== 1'b1) begin bad++; $display("FAIL pos_done: got %0d want 1", update_done); end
            total++; if ({minus_on, tens_digit, ones_digit} !== {1'b0, 4'd1, 4'd5})
               begin bad++; $display("FAIL pos_digits: got %0d/%0d/%0d want 0/1/5", minus_on, tens_digit, ones_digit); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL pos_busy_clr: got %0d want 0", busy); end
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL pos_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_negative();
      int pulses = 0;
      do_reset(1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         if (update_done === 1'b1) pulses++;
         if (i == 4) begin
            total++; if ({update_done, minus_on, tens_digit, ones_digit} !== {1'b1, 1'b1, 4'd2, 4'd7})
               begin bad++; $display("FAIL neg_digits: got done=%0d %0d/%0d/%0d want 1 1/2/7", update_done, minus_on, tens_digit, ones_digit); end
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL neg_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_saturate();
      bit want_vis;
      do_reset(1'b0);
      repeat (7) tick(1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         if (i == 10) begin
            total++; if (busy !== 1'b1 || update_done !== 1'b0) begin bad++; $display("FAIL sat_busy10: got busy=%0d done=%0d want 1 0", busy, update_done); end
         end
         if (i == 11) begin
            total++; if ({update_done, minus_on, tens_digit, ones_digit} !== {1'b1, 1'b0, 4'd9, 4'd9})
               begin bad++; $display("FAIL sat_digits: got done=%0d %0d/%0d/%0d want 1 0/9/9", update_done, minus_on, tens_digit, ones_digit); end
         end
      end
      for (int k = 2; k <= 20; k++) begin
         tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
         want_vis = ((k / BLINK_FRAMES) % 2) == 0;
         total++; if (digits_visible !== want_vis) begin bad++; $display("FAIL sat_blink frame %0d: got %0d want %0d", k, digits_visible, want_vis); end
      end
      tick(1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      total++; if (digits_visible !== 1'b1) begin bad++; $display("FAIL sat_unblink: got %0d want 1", digits_visible); end
   endtask

   task automatic test_simultaneous();
      do_reset(1'b0);
      tick(1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      total++; if ({update_done, minus_on, tens_digit, ones_digit} !== {1'b1, 1'b0, 4'd0, 4'd7})
         begin bad++; $display("FAIL both_pulses: got done=%0d %0d/%0d/%0d want 1 0/0/7", update_done, minus_on, tens_digit, ones_digit); end
      tick(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      total++; if ({update_done, minus_on, tens_digit, ones_digit} !== {1'b1, 1'b1, 4'd0, 4'd8})
         begin bad++; $display("FAIL small_neg: got done=%0d %0d/%0d/%0d want 1 1/0/8", update_done, minus_on, tens_digit, ones_digit); end
      tick(1'b1, 1'b1, 1'b0, 4'd9, 1'b1);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      total++; if ({update_done, minus_on, tens_digit, ones_digit} !== {1'b1, 1'b0, 4'd0, 4'd0})
         begin bad++; $display("FAIL clear_add: got done=%0d %0d/%0d/%0d want 1 0/0/0", update_done, minus_on, tens_digit, ones_digit); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      do_reset(1'b0);
      repeat (6) tick(1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         tick((i == 3) || (i == 11), 1'b0, 1'b0, 4'd0, 1'b0);
         if (update_done === 1'b1) pulses++;
         if (i == 11) begin
            total++; if ({update_done, tens_digit, ones_digit} !== {1'b1, 4'd9, 4'd0})
               begin bad++; $display("FAIL b2b_digits: got done=%0d %0d/%0d want 1 9/0", update_done, tens_digit, ones_digit); end
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
      tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      do_reset(1'b1);
      total++; if ({busy, update_done, minus_on, tens_digit, ones_digit} !== 11'd0)
         begin bad++; $display("FAIL abort_state: got busy=%0d done=%0d %0d/%0d/%0d want all 0", busy, update_done, minus_on, tens_digit, ones_digit); end
      pulses = 0;
      repeat (14) begin
         tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         if (update_done === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
   endtask

   task automatic test_random();
      bit sof, add, sub, clr;
      int r, phase;
      do_reset(1'b0);
      for (int n = 0; n < 1200; n++) begin
         phase = (n / 300) % 2;
         r   = $urandom_range(0, 9);
         sof = ($urandom_range(0, 4) == 0);
         add = phase ? (r < 3) : (r < 6);
         sub = phase ? (r >= 2 && r < 8) : (r >= 5 && r < 7);
         clr = ($urandom_range(0, 99) == 0);
         tick(sof, add, sub, 4'($urandom_range(0, 15)), clr);
         total++; if (minus_on !== m_minus)        begin bad++; $display("FAIL rnd_minus @%0d: got %0d want %0d", n, minus_on, m_minus); end
         total++; if (tens_digit !== 4'(m_tens))   begin bad++; $display("FAIL rnd_tens @%0d: got %0d want %0d", n, tens_digit, m_tens); end
         total++; if (ones_digit !== 4'(m_ones))   begin bad++; $display("FAIL rnd_ones @%0d: got %0d want %0d", n, ones_digit, m_ones); end
         total++; if (digits_visible !== m_vis)    begin bad++; $display("FAIL rnd_vis @%0d: got %0d want %0d", n, digits_visible, m_vis); end
         total++; if (busy !== m_busy)             begin bad++; $display("FAIL rnd_busy @%0d: got %0d want %0d", n, busy, m_busy); end
         total++; if (update_done !== m_done)      begin bad++; $display("FAIL rnd_done @%0d: got %0d want %0d", n, update_done, m_done); end
      end
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; add_pulse = 1'b0; sub_pulse = 1'b0; amount = 4'd0; clear = 1'b0;
      edge_n = 0;
      test_reset();
      test_positive();
      test_negative();
      test_saturate();
      test_simultaneous();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_sign_ctrl.md
SCORE_SIGN_CTRL -- requirements
Module: score_sign_ctrl

Interface
REQ-001 SHALL have parameter MAX_ABS, default 99, meaning the saturation magnitude of the score (legal range 1..99).
REQ-002 SHALL have parameter BLINK_FRAMES, default 16, meaning the number of frames per blink phase while at the limit (legal range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port startOfFrame, input, 1 bit: a one-cycle pulse at the start of each VGA frame.
REQ-006 SHALL have port add_pulse, input, 1 bit: add amount to the score this cycle.
REQ-007 SHALL have port sub_pulse, input, 1 bit: subtract amount from the score this cycle.
REQ-008 SHALL have port amount, input, 4 bits: unsigned step size, 0..15.
REQ-009 SHALL have port clear, input, 1 bit: force the score to 0.
REQ-010 SHALL have port minus_on, output, 1 bit: feeds the minus-sign bitmap on/off input; 1 means the displayed score is negative.
REQ-011 SHALL have port tens_digit, output, 4 bits: displayed tens digit in BCD, 0..9.
REQ-012 SHALL have port ones_digit, output, 4 bits: displayed ones digit in BCD, 0..9.
REQ-013 SHALL have port digits_visible, output, 1 bit: blink gate for the sign and digit bitmaps.
REQ-014 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-015 SHALL have port update_done, output, 1 bit: one-cycle pulse when new display values are latched.

Function
REQ-016 SHALL hold the score as an 8-bit signed two's-complement register, computing each update in 9-bit signed and saturating to [-MAX_ABS, +MAX_ABS].
REQ-017 SHALL apply updates at the clock edge with the priority: clear (score=0) > add_pulse and sub_pulse together (no change) > add_pulse (score+amount) > sub_pulse (score-amount).
REQ-018 SHALL leave the score unchanged when amount=0.
REQ-019 SHALL use a state machine with states IDLE, CONVERT and DONE; the reset state SHALL be IDLE.
REQ-020 In IDLE, when startOfFrame=1, SHALL snapshot the sign and magnitude of the score (including any update in the same cycle), clear the tens counter, set busy=1 and go to CONVERT.
REQ-021 In CONVERT, SHALL subtract 10 from the remainder and increment tens each cycle while the remainder is >= 10; otherwise it SHALL go to DONE.
REQ-022 In DONE, SHALL register minus_on (snapshot<0), tens_digit, ones_digit=remainder and update_done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-023 Latency: the outputs SHALL change tens+2 clock edges after the edge that sampled startOfFrame (magnitude 15: 3 edges; magnitude 99: 11 edges).
REQ-024 SHALL ignore startOfFrame in CONVERT and DONE; the conversion in progress continues unaffected.
REQ-025 Score changes during a conversion SHALL be accepted but SHALL NOT alter the snapshot being converted.
REQ-026 A score of zero SHALL never give minus_on=1.
REQ-027 SHALL keep minus_on, tens_digit and ones_digit stable between update_done pulses.
REQ-028 SHALL define at_limit internally as |score| == MAX_ABS, evaluated on each startOfFrame.
REQ-029 While at_limit, SHALL increment an 8-bit frame counter on each startOfFrame; on reaching BLINK_FRAMES-1 the counter SHALL wrap to 0 and digits_visible SHALL toggle.
REQ-030 On a startOfFrame with at_limit false, SHALL set the frame counter to 0 and digits_visible to 1.

Reset
REQ-031 When resetN=0 at a clock edge, SHALL set the score to 0, the state to IDLE, busy to 0, update_done to 0, minus_on to 0, tens_digit to 0, ones_digit to 0, digits_visible to 1 and the frame counter to 0.
REQ-032 Reset during CONVERT or DONE SHALL abort the conversion with no update_done pulse; reset SHALL take precedence over all other inputs.

Verification
REQ-033 SHALL verify: after reset, three add_pulse with amount=5, then startOfFrame -> 3 edges later minus_on=0, tens=1, ones=5, update_done pulses once.
REQ-034 SHALL verify: from 0, three sub_pulse with amount=9, then startOfFrame -> minus_on=1, tens=2, ones=7.
REQ-035 SHALL verify: seven add_pulse with amount=15 -> score saturates at 99; digits 9/9 after 11 edges; digits_visible toggles every 16 startOfFrame pulses; one sub_pulse with amount=1 -> next frame digits_visible=1.
REQ-036 SHALL verify: add_pulse and sub_pulse in the same cycle -> score unchanged; clear with add_pulse in the same cycle -> score 0 and minus_on=0 after conversion.
REQ-037 SHALL verify: a second startOfFrame during CONVERT -> ignored (a single update_done pulse); resetN=0 mid-CONVERT -> busy=0, all digits 0, no update_done.
